// File: rtl/codes_pkg.sv
// Shared core types: the 32-bit word type, ifetch FSM states and the PC reset vector.
package codes;

   typedef logic [31:0] size_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2,
      HALT = 2'd3
   } ifetch_state_t;

   localparam size_t RESET_VECTOR_C = 32'hBFC0_0000;

endpackage

// File: rtl/ifetch.sv
// Instruction fetch unit: owns the PC, issues word reads, applies one-slot branch delay and halts on fetch from 0.
// Optional IFETCH_MISALIGN_TRAP_EN adds fault_o and traps fetches from non-word-aligned PCs.
import codes::*;

module ifetch #(
   parameter size_t RESET_VECTOR = RESET_VECTOR_C
) (
   input  logic        clk,
   input  logic        reset_i,
   input  logic        fetch_i,
   input  logic        jump_i,
   input  size_t       jump_addr_i,
   output size_t       address_o,
   output logic        read_o,
   input  logic        waitrequest_i,
   input  size_t       readdata_i,
   output size_t       instr_o,
   output logic        instr_valid_o,
   output size_t       pc_o,
   output logic        busy_o,
`ifdef IFETCH_MISALIGN_TRAP_EN
   output logic        fault_o,
`endif
   output logic        halted_o
);

   ifetch_state_t state, state_nxt;
   size_t         fetch_pc, target;
   logic          pend, armed;
   logic          trap;

`ifdef IFETCH_MISALIGN_TRAP_EN
   assign trap = (fetch_pc[1:0] != 2'b00);
`else
   assign trap = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (fetch_i) state_nxt = (fetch_pc == '0 || trap) ? HALT : REQ;
         REQ:  if (!waitrequest_i) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         HALT: state_nxt = HALT;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy_o        = (state != IDLE);
      instr_valid_o = (state == DONE);
      halted_o      = (state == HALT);
   end

   // Bus side is registered; address is latched on entry to REQ so it is stable through stalls.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         read_o    <= 1'b0;
         address_o <= RESET_VECTOR;
      end else begin
         read_o <= (state_nxt == REQ);
         if (state == IDLE && state_nxt == REQ) address_o <= {fetch_pc[31:2], 2'b00};
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         instr_o <= '0;
         pc_o    <= '0;
      end else if (state == REQ && !waitrequest_i) begin
         instr_o <= readdata_i;
         pc_o    <= fetch_pc;
      end
   end

   // A jump seen in DONE is recorded first, so that same advance is already the delay slot.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         fetch_pc <= RESET_VECTOR;
         target   <= '0;
         pend     <= 1'b0;
         armed    <= 1'b0;
      end else if (state == DONE) begin
         if (jump_i) begin
            target   <= jump_addr_i;
            pend     <= 1'b0;
            armed    <= 1'b1;
            fetch_pc <= fetch_pc + 32'd4;
         end else if (armed) begin
            fetch_pc <= target;
            armed    <= 1'b0;
         end else begin
            fetch_pc <= fetch_pc + 32'd4;
            if (pend) begin
               pend  <= 1'b0;
               armed <= 1'b1;
            end
         end
      end else if (jump_i) begin
         target <= jump_addr_i;
         pend   <= 1'b1;
         armed  <= 1'b0;
      end
   end

`ifdef IFETCH_MISALIGN_TRAP_EN
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i)                                 fault_o <= 1'b0;
      else if (state == IDLE && fetch_i && trap)   fault_o <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: vector table, hand-written corner sequences, then random fetches vs a PC model.
module tb_ifetch;
   import codes::*;

   logic  clk = 1'b0;
   logic  reset_i, fetch_i, jump_i, waitrequest_i;
   size_t jump_addr_i, readdata_i;
   size_t address_o, instr_o, pc_o;
   logic  read_o, instr_valid_o, busy_o, halted_o;
`ifdef IFETCH_MISALIGN_TRAP_EN
   logic  fault_o;
`endif

   ifetch #(.RESET_VECTOR(32'hBFC0_0000)) dut (
      .clk           (clk),
      .reset_i       (reset_i),
      .fetch_i       (fetch_i),
      .jump_i        (jump_i),
      .jump_addr_i   (jump_addr_i),
      .address_o     (address_o),
      .read_o        (read_o),
      .waitrequest_i (waitrequest_i),
      .readdata_i    (readdata_i),
      .instr_o       (instr_o),
      .instr_valid_o (instr_valid_o),
      .pc_o          (pc_o),
      .busy_o        (busy_o),
`ifdef IFETCH_MISALIGN_TRAP_EN
      .fault_o       (fault_o),
`endif
      .halted_o      (halted_o)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference PC model: rem = number of +4 steps still to take before jumping to tgt (-1: none pending)
   size_t m_pc, m_tgt;
   int    m_rem;

   typedef struct {
      int    waits;
      size_t data;
      int    jmode;   // 0 none, 1 idle cycle before fetch, 2 first REQ cycle, 3 DONE cycle
      size_t jaddr;
      size_t exp_pc;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_pc  = 32'hBFC0_0000;
      m_tgt = '0;
      m_rem = -1;
   endtask

   task automatic do_reset();
      reset_i = 1'b1; fetch_i = 1'b0; jump_i = 1'b0; waitrequest_i = 1'b0;
      cyc(); cyc();
      reset_i = 1'b0;
      cyc();
      model_reset();
   endtask

   task automatic do_fetch(input int waits, input size_t data, input int jmode,
                           input size_t jaddr, input size_t exp_pc, input string tag);
      if (jmode == 1) begin
         jump_i = 1'b1; jump_addr_i = jaddr;
         cyc();
         jump_i = 1'b0;
         m_tgt = jaddr; m_rem = 1;
      end
      fetch_i = 1'b1;
      cyc();
      for (int c = 1; c <= waits + 1; c++) begin
         waitrequest_i = (c <= waits);
         readdata_i    = (c <= waits) ? ~data : data;
         fetch_i       = 1'($urandom_range(0, 1));
         if (c == 1 && jmode == 2) begin
            jump_i = 1'b1; jump_addr_i = jaddr;
            m_tgt = jaddr; m_rem = 1;
         end
         chk({tag, " read_o"}, read_o, 1);
         chk({tag, " address_o"}, address_o, {exp_pc[31:2], 2'b00});
         chk({tag, " early valid"}, instr_valid_o, 0);
         cyc();
         jump_i = 1'b0;
      end
      waitrequest_i = 1'b1;
      readdata_i    = 32'hDEAD_BEEF;
      chk({tag, " instr_valid_o"}, instr_valid_o, 1);
      chk({tag, " read_o done"}, read_o, 0);
      chk({tag, " instr_o"}, instr_o, data);
      chk({tag, " pc_o"}, pc_o, exp_pc);
      if (jmode == 3) begin
         jump_i = 1'b1; jump_addr_i = jaddr;
         m_tgt = jaddr; m_rem = 0; m_pc = m_pc + 32'd4;
      end else if (m_rem == 0) begin
         m_pc = m_tgt; m_rem = -1;
      end else begin
         m_pc = m_pc + 32'd4;
         if (m_rem > 0) m_rem--;
      end
      cyc();
      jump_i = 1'b0; fetch_i = 1'b0; waitrequest_i = 1'b0;
      chk({tag, " valid pulse"}, instr_valid_o, 0);
      chk({tag, " busy idle"}, busy_o, 0);
      chk({tag, " instr hold"}, instr_o, data);
   endtask

   initial begin
      size_t r, ja;
      int    jm;

      tbl[0] = '{0, 32'h2408_0005, 3, 32'hBFC0_0100, 32'hBFC0_0000};
      tbl[1] = '{3, 32'h1111_1111, 0, 32'h0,         32'hBFC0_0004};
      tbl[2] = '{0, 32'h2222_2222, 0, 32'h0,         32'hBFC0_0100};
      tbl[3] = '{1, 32'h3333_3333, 1, 32'hBFC0_0200, 32'hBFC0_0104};
      tbl[4] = '{0, 32'h4444_4444, 0, 32'h0,         32'hBFC0_0108};
      tbl[5] = '{2, 32'h5555_5555, 2, 32'hBFC0_0300, 32'hBFC0_0200};
      tbl[6] = '{0, 32'h6666_6666, 3, 32'hBFC0_0400, 32'hBFC0_0204};
      tbl[7] = '{1, 32'h7777_7777, 0, 32'h0,         32'hBFC0_0208};
      tbl[8] = '{0, 32'h8888_8888, 3, 32'h0,         32'hBFC0_0400};

      reset_i = 1'b1; fetch_i = 1'b0; jump_i = 1'b0; waitrequest_i = 1'b0;
      jump_addr_i = '0; readdata_i = '0;
      #1;
      chk("rst read_o", read_o, 0);
      chk("rst address_o", address_o, 32'hBFC0_0000);
      chk("rst instr_o", instr_o, 0);
      chk("rst pc_o", pc_o, 0);
      chk("rst instr_valid_o", instr_valid_o, 0);
      chk("rst busy_o", busy_o, 0);
      chk("rst halted_o", halted_o, 0);
      do_reset();
      chk("idle read_o", read_o, 0);

      foreach (tbl[i])
         do_fetch(tbl[i].waits, tbl[i].data, tbl[i].jmode, tbl[i].jaddr, tbl[i].exp_pc,
                  $sformatf("tbl%0d", i));

      // Delay slot after the jump to 0, then the next fetch must halt without a read.
      do_fetch(1, 32'hAAAA_0001, 0, 32'h0, 32'hBFC0_0404, "slot0");
      fetch_i = 1'b1;
      cyc();
      chk("halt halted_o", halted_o, 1);
      chk("halt busy_o", busy_o, 1);
      for (int k = 0; k < 8; k++) begin
         fetch_i = 1'($urandom_range(0, 1));
         chk("halt read_o", read_o, 0);
         cyc();
      end
      fetch_i = 1'b0;
      chk("halt sticky", halted_o, 1);
      chk("halt instr hold", instr_o, 32'hAAAA_0001);
      chk("halt pc hold", pc_o, 32'hBFC0_0404);

      // Reset in the middle of a stalled read.
      do_reset();
      chk("post-rst halted_o", halted_o, 0);
      do_fetch(0, 32'h0BAD_F00D, 0, 32'h0, 32'hBFC0_0000, "pre-stall");
      fetch_i = 1'b1; waitrequest_i = 1'b1;
      cyc();
      fetch_i = 1'b0;
      chk("stall read_o", read_o, 1);
      chk("stall address_o", address_o, 32'hBFC0_0004);
      cyc();
      #2;
      reset_i = 1'b1;
      #1;
      chk("async rst read_o", read_o, 0);
      chk("async rst busy_o", busy_o, 0);
      chk("async rst pc_o", pc_o, 0);
      cyc();
      reset_i = 1'b0; waitrequest_i = 1'b0;
      cyc();
      model_reset();
      do_fetch(0, 32'h1234_5678, 0, 32'h0, 32'hBFC0_0000, "after-rst");

      // Jump to a misaligned target.
      do_reset();
      do_fetch(0, 32'h0000_0011, 3, 32'hBFC0_0102, 32'hBFC0_0000, "mis-j");
      do_fetch(0, 32'h0000_0022, 0, 32'h0, 32'hBFC0_0004, "mis-slot");
`ifdef IFETCH_MISALIGN_TRAP_EN
      fetch_i = 1'b1;
      cyc();
      fetch_i = 1'b0;
      chk("mis fault_o", fault_o, 1);
      chk("mis halted_o", halted_o, 1);
      for (int k = 0; k < 4; k++) begin
         chk("mis read_o", read_o, 0);
         cyc();
      end
`else
      do_fetch(1, 32'h0000_0033, 0, 32'h0, 32'hBFC0_0102, "mis-tgt");
      do_fetch(0, 32'h0000_0044, 0, 32'h0, 32'hBFC0_0106, "mis-next");
`endif

      // Random fetches against the PC model.
      do_reset();
      for (int n = 0; n < 60; n++) begin
         r  = $urandom();
         ja = {4'hB, r[27:2], 2'b00};
         jm = $urandom_range(0, 6);
         if (jm > 3) jm = 0;
         for (int g = $urandom_range(0, 2); g > 0; g--) begin
            chk("rnd gap read_o", read_o, 0);
            cyc();
         end
         do_fetch($urandom_range(0, 3), $urandom(), jm, ja, m_pc, $sformatf("rnd%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit for the multi-cycle MIPS core. It owns the program counter and issues word reads on the Avalon-style instruction/data bus. It delivers each fetched word to the instruction register / field decoder as `instr_o`, together with its address. It also applies MIPS branch-delay-slot semantics to jump/branch redirects and detects the halt condition (fetch from address 0).

## Interface
- `RESET_VECTOR`, default 32'hBFC0_0000: PC value after reset.
- `clk`  in  1  system clock, rising edge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `fetch_i`  in  1  request the next instruction; the control FSM drives it in FETCH.
- `jump_i`  in  1  one-cycle redirect strobe from EXEC.
- `jump_addr_i`  in  32  redirect target; sampled with `jump_i`.
- `address_o`  out  32  bus byte address, word-aligned.
- `read_o`  out  1  bus read request.
- `waitrequest_i`  in  1  bus stall.
- `readdata_i`  in  32  bus read data.
- `instr_o`  out  32  last fetched instruction word (`size_t`).
- `instr_valid_o`  out  1  one-cycle pulse: `instr_o` has just been updated.
- `pc_o`  out  32  address of the instruction in `instr_o`.
- `busy_o`  out  1  fetch FSM is not in IDLE.
- `halted_o`  out  1  sticky; set when a fetch targets address 0.

## Operation
- FSM states (`ifetch_state_t`): IDLE, REQ, DONE, HALT.
- IDLE:
  - `fetch_i`=1 and `fetch_pc`≠0 → REQ.
  - `fetch_i`=1 and `fetch_pc`=0 → HALT; no bus read is issued.
- REQ:
  - `read_o`=1 and `address_o`=`fetch_pc`, both held stable while `waitrequest_i`=1.
  - When `waitrequest_i`=0, the data is accepted in that cycle: `instr_o`←`readdata_i` and `pc_o`←`fetch_pc` → DONE.
- DONE: `instr_valid_o`=1 for this cycle only. `fetch_pc` advances, then → IDLE.
- HALT: absorbing state; only reset leaves it. `halted_o`=1.
- PC advance on each accepted word:
  - If a redirect is armed (see below): `fetch_pc`←`target`.
  - Otherwise: `fetch_pc`←`fetch_pc`+4 (modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal and then halts on the next fetch).
- Delay slot:
  - `jump_i` stores `target`←`jump_addr_i` and sets `pend`=1.
  - The next accepted word is the delay slot and still advances by +4. At that advance, `pend` moves to `armed`.
  - The advance after that uses `target` and clears `armed`.
- A second `jump_i` while `pend` or `armed` is set overwrites `target` and restarts the sequence at `pend`.
- `fetch_i` while `busy_o`=1 is ignored.
- `jump_i` arriving in the same cycle as a DONE advance is recorded first; that advance still counts as the delay slot.
- `instr_o` and `pc_o` hold their values until the next accepted word.

## Timing
- Reset values:
  - Internal: `fetch_pc`=`RESET_VECTOR`, state=IDLE, `pend`=`armed`=0, `target`=0.
  - Outputs: `read_o`=0, `address_o`=`RESET_VECTOR`, `instr_o`=0, `pc_o`=0, `instr_valid_o`=0, `busy_o`=0, `halted_o`=0.
- Latency: with `fetch_i` at cycle 0 and zero wait states, `read_o` is high in cycle 1 and `instr_valid_o` in cycle 2. Each wait-state cycle adds one cycle.
- `read_o` and `address_o` are registered outputs.
- Reset asserted mid-REQ drops `read_o` immediately (asynchronously). The outstanding read is abandoned.

## Configuration
- `IFETCH_MISALIGN_TRAP_EN` defined:
  - Adds output `fault_o` (1 bit, reset 0, sticky).
  - A fetch request with `fetch_pc[1:0]`≠0 goes to HALT with `fault_o`=1 and issues no read.
  - `halted_o` is also set.
- Macro not defined: there is no `fault_o` port. `address_o` is `{fetch_pc[31:2],2'b00}` and bits [1:0] are ignored.

## Structure
- Shared package `codes`:
  - Add `ifetch_state_t`.
  - Add constant `RESET_VECTOR_C` (32'hBFC0_0000).
  - Reuse `size_t` for all 32-bit words.
- No sub-module; the PC/redirect logic and the FSM live in one file.

## Test plan
- **Reset then fetch, zero wait:** `readdata_i`=32'h2408_0005 → `address_o`=32'hBFC0_0000 in cycle 1; `instr_valid_o` in cycle 2; `instr_o`=32'h2408_0005, `pc_o`=32'hBFC0_0000.
- **Three wait states:** `waitrequest_i` high for 3 cycles → `address_o` and `read_o` stable throughout; `instr_valid_o` arrives in cycle 5.
- **Jump handling:** `jump_i` with `jump_addr_i`=32'hBFC0_0100 after the fetch at 32'hBFC0_0000 → the next fetches are 32'hBFC0_0004 (delay slot), then 32'hBFC0_0100.
- **Halt:** `jump_addr_i`=0 → the delay slot is fetched, the next `fetch_i` gives `halted_o`=1, and `read_o` never rises again.
- **Reset during a stall:** reset asserted in REQ with `waitrequest_i`=1 → `read_o`=0 in the same cycle; after release, the next fetch is from `RESET_VECTOR`.
- **Misalign (macro defined only):** `jump_addr_i`=32'hBFC0_0102 → `fault_o`=1, `halted_o`=1, no read at 32'hBFC0_0102.
